// File: rtl/rx_fifo_p_pkg.sv
// rtl/rx_fifo_p_pkg.sv - shared flit type and depth legality check for the receive link stage
`ifndef SIZE
`define SIZE 8
`endif

package rx_fifo_p_pkg;

    typedef logic [`SIZE-1:0] flit_t;

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO, registered write, combinational head read
module fifo_sync
    import rx_fifo_p_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("fifo_sync: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;
    assign full    = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rp];

    // Storage is deliberately left out of reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_rd) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rx_fifo_p.sv
// rtl/rx_fifo_p.sv - receive link stage: two-phase in, FIFO, two-phase out to local router
module rx_fifo_p
    import rx_fifo_p_pkg::*;
#(
    parameter int    routerid = -1,
    parameter string port     = "unknown",
    parameter int    DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req1,
    input  flit_t                  data1,
    output logic                   ack1,
    output logic                   req2,
    output flit_t                  data2,
    input  logic                   ack2,
    output logic [$clog2(DEPTH):0] count
);
    if (routerid < -1) begin : g_bad_id
        $error("rx_fifo_p: routerid below -1");
    end
    if (port == "") begin : g_bad_port
        $error("rx_fifo_p: empty port label");
    end

    flit_t w_head;
    logic  w_full;
    logic  w_empty;
    logic  w_wr;
    logic  w_issue;
    logic  w_complete;

    logic  r_ack1;
    logic  r_req2;
    logic  r_busy;
    flit_t r_data2;

    assign w_wr       = (req1 != r_ack1) && !w_full;
    assign w_issue    = !r_busy && !w_empty && (r_req2 == ack2);
    // Head entry is held in the FIFO until the router acks, so count covers the in-flight flit.
    assign w_complete = r_busy && (r_req2 == ack2);

    fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(flit_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (w_wr),
        .wr_data (data1),
        .rd_en   (w_complete),
        .rd_data (w_head),
        .count   (count),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ack1  <= 1'b0;
            r_req2  <= 1'b0;
            r_busy  <= 1'b0;
            r_data2 <= '0;
        end else begin
            if (w_wr) begin
                r_ack1 <= ~r_ack1;
            end
            if (w_issue) begin
                r_data2 <= w_head;
                r_req2  <= ~r_req2;
                r_busy  <= 1'b1;
            end else if (w_complete) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign ack1  = r_ack1;
    assign req2  = r_req2;
    assign data2 = r_data2;

endmodule

// File: tb/tb_rx_fifo_p.sv
// tb/tb_rx_fifo_p.sv - scoreboard bench for rx_fifo_p
module tb_rx_fifo_p;

    logic       clk = 1'b0;
    logic       reset;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    logic       req2;
    logic [7:0] data2;
    logic       ack2;
    logic [2:0] count;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         ack1_toggles = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;
    always @(ack1) ack1_toggles++;

    rx_fifo_p #(
        .routerid (3),
        .port     ("east"),
        .DEPTH    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req1  (req1),
        .data1 (data1),
        .ack1  (ack1),
        .req2  (req2),
        .data2 (data2),
        .ack2  (ack2),
        .count (count)
    );

    task automatic send_flit(input logic [7:0] d);
        int i;
        for (i = 0; i < 200 && (req1 !== ack1); i++) @(negedge clk);
        total_cnt++;
        if (req1 !== ack1) begin
            $display("FAIL send_timeout req1=%b ack1=%b required equal", req1, ack1);
        end else begin
            pass_cnt++;
            data1 = d;
            req1  = ~req1;
            sb_q.push_back(d);
        end
    endtask

    task automatic recv_flit(input int delay);
        int i;
        logic [7:0] exp;
        for (i = 0; i < 200 && (req2 === ack2); i++) @(negedge clk);
        total_cnt++;
        if (req2 === ack2) begin
            $display("FAIL recv_timeout req2=%b ack2=%b required different", req2, ack2);
        end else if (sb_q.size() == 0) begin
            $display("FAIL recv_unexpected data2=%h required no flit", data2);
        end else begin
            exp = sb_q.pop_front();
            if (data2 !== exp) $display("FAIL recv_data data2=%h required %h", data2, exp);
            else pass_cnt++;
            repeat (delay) @(negedge clk);
            ack2 = ~ack2;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req1  = 1'b0;
        ack2  = 1'b0;
        data1 = 8'h00;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({ack1, req2, data2, count} !== 13'd0)
            $display("FAIL reset_state got %b required 0", {ack1, req2, data2, count});
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        data1 = 8'hA5;
        req1  = ~req1;
        sb_q.push_back(8'hA5);
        @(negedge clk);
        total_cnt++;
        if ({ack1, req2, count} !== {1'b1, 1'b0, 3'd1})
            $display("FAIL single_write ack1/req2/count=%b required 1/0/001", {ack1, req2, count});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({req2, count} !== {1'b1, 3'd1})
            $display("FAIL single_issue req2/count=%b required 1/001", {req2, count});
        else pass_cnt++;
        recv_flit(0);
        @(negedge clk);
        total_cnt++;
        if (count !== 3'd0) $display("FAIL single_complete count=%0d required 0", count);
        else pass_cnt++;
    endtask

    task automatic test_fill_full();
        int t0;
        t0 = ack1_toggles;
        for (int i = 1; i <= 5; i++) send_flit(8'(i));
        repeat (4) @(negedge clk);
        total_cnt++;
        if (ack1_toggles - t0 != 4) $display("FAIL full_ack1_toggles got %0d required 4", ack1_toggles - t0);
        else pass_cnt++;
        total_cnt++;
        if (count !== 3'd4) $display("FAIL full_count count=%0d required 4", count);
        else pass_cnt++;
        total_cnt++;
        if (req1 === ack1) $display("FAIL full_pending req1=%b ack1=%b required different", req1, ack1);
        else pass_cnt++;
        recv_flit(0);
        @(negedge clk);
        total_cnt++;
        if (count !== 3'd3 || req1 === ack1)
            $display("FAIL full_free count=%0d pending=%b required 3/1", count, req1 ^ ack1);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (count !== 3'd4 || ack1_toggles - t0 != 5)
            $display("FAIL full_refill count=%0d toggles=%0d required 4/5", count, ack1_toggles - t0);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) recv_flit(0);
        repeat (2) @(negedge clk);
        total_cnt++;
        if (count !== 3'd0) $display("FAIL full_drain count=%0d required 0", count);
        else pass_cnt++;
    endtask

    task automatic test_ordering();
        int maxc = 0;
        bit done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send_flit(8'(8'h10 + i));
            end
            begin
                for (int j = 0; j < 16; j++) recv_flit(int'($urandom_range(0, 5)));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (int'(count) > maxc) maxc = int'(count);
                end
            end
        join
        total_cnt++;
        if (maxc > 4) $display("FAIL order_max_count got %0d required <=4", maxc);
        else pass_cnt++;
        total_cnt++;
        if (sb_q.size() != 0) $display("FAIL order_leftover got %0d required 0", sb_q.size());
        else pass_cnt++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        send_flit(8'h21);
        send_flit(8'h22);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (count !== 3'd2 || req2 === ack2)
            $display("FAIL simul_setup count=%0d busy=%b required 2/1", count, req2 ^ ack2);
        else pass_cnt++;
        recv_flit(0);
        send_flit(8'h23);
        @(negedge clk);
        total_cnt++;
        if (count !== 3'd2) $display("FAIL simul_count count=%0d required 2", count);
        else pass_cnt++;
        recv_flit(0);
        recv_flit(0);
        repeat (2) @(negedge clk);
        total_cnt++;
        if (count !== 3'd0) $display("FAIL simul_drain count=%0d required 0", count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        send_flit(8'h31);
        send_flit(8'h32);
        send_flit(8'h33);
        repeat (4) @(negedge clk);
        total_cnt++;
        if (count !== 3'd3 || req2 === ack2)
            $display("FAIL rstmid_setup count=%0d busy=%b required 3/1", count, req2 ^ ack2);
        else pass_cnt++;
        #2;
        reset = 1'b0;
        req1  = 1'b0;
        ack2  = 1'b0;
        data1 = 8'h00;
        sb_q.delete();
        #1;
        total_cnt++;
        if ({ack1, req2, data2, count} !== 13'd0)
            $display("FAIL rstmid_async got %b required 0", {ack1, req2, data2, count});
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_flit(8'h3C);
        recv_flit(0);
        total_cnt++;
        if (req2 !== 1'b1) $display("FAIL rstmid_req2 req2=%b required 1", req2);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (count !== 3'd0) $display("FAIL rstmid_drain count=%0d required 0", count);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 9; i++) begin
            send_flit(8'(8'h50 + i));
            recv_flit(0);
        end
        repeat (2) @(negedge clk);
        total_cnt++;
        if (count !== 3'd0) $display("FAIL wrap_count count=%0d required 0", count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_full();
        test_ordering();
        test_simultaneous();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
